// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy hit detector slice.
// - enemy_life_t : life-cycle states of the enemy
// - NUM_SHOTS    : number of player shots tracked in parallel
// - SCREEN_W     : visible screen width in pixels
// - sat_inc8     : saturating 8-bit increment used by the hit counter
package enemy_pkg;

    typedef enum logic [1:0] {
        ALIVE,
        HIT_REPORT,
        DEAD
    } enemy_life_t;

    localparam int NUM_SHOTS   = 3;
    localparam int SCREEN_W    = 640;
    localparam int HIT_COUNT_W = 8;

    function automatic logic [HIT_COUNT_W-1:0] sat_inc8(input logic [HIT_COUNT_W-1:0] value);
        return (value == {HIT_COUNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/enemy_dodge_zone.sv
// Dodge zone detector: flags pixels lying in the rectangle below the enemy
// where an incoming shot should make it dodge.
// Ports:
//   clk, resetN            clock, asynchronous active-low reset
//   pixelX, pixelY         current VGA pixel
//   topLeftX, topLeftY     enemy top-left corner
//   zone_flag_d            zone flag delayed one cycle, aligned with the
//                          registered drawing requests
module enemy_dodge_zone #(
    parameter int OBJECT_WIDTH_X  = 30,
    parameter int OBJECT_HEIGHT_Y = 30,
    parameter int DODGE_MARGIN_X  = 16,
    parameter int DODGE_RANGE_Y   = 96
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [10:0] topLeftX,
    input  logic [10:0] topLeftY,
    output logic        zone_flag_d
);

    localparam logic signed [11:0] WIDTH_S  = 12'(OBJECT_WIDTH_X);
    localparam logic signed [11:0] HEIGHT_S = 12'(OBJECT_HEIGHT_Y);
    localparam logic signed [11:0] MARGIN_S = 12'(DODGE_MARGIN_X);
    localparam logic signed [11:0] RANGE_S  = 12'(DODGE_RANGE_Y);

    logic signed [11:0] px_s;
    logic signed [11:0] py_s;
    logic signed [11:0] tlx_s;
    logic signed [11:0] tly_s;
    logic signed [11:0] x_lo_raw;
    logic signed [11:0] x_lo;
    logic signed [11:0] x_hi;
    logic signed [11:0] y_lo;
    logic signed [11:0] y_hi;
    logic               in_zone;

    // Signed arithmetic with one spare bit: an enemy close to the left edge
    // gives a negative lower bound that is clamped to 0 instead of wrapping
    // to a huge unsigned value near 2047.
    always_comb begin
        px_s     = signed'({1'b0, pixelX});
        py_s     = signed'({1'b0, pixelY});
        tlx_s    = signed'({1'b0, topLeftX});
        tly_s    = signed'({1'b0, topLeftY});
        x_lo_raw = tlx_s - MARGIN_S;
        x_lo     = x_lo_raw[11] ? 12'sd0 : x_lo_raw;
        x_hi     = tlx_s + WIDTH_S + MARGIN_S;
        y_lo     = tly_s + HEIGHT_S;
        y_hi     = y_lo + RANGE_S;
        in_zone  = (px_s >= x_lo) && (px_s < x_hi) && (py_s >= y_lo) && (py_s < y_hi);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            zone_flag_d <= 1'b0;
        end else begin
            zone_flag_d <= in_zone;
        end
    end

endmodule

// File: rtl/enemy_hit_detector.sv
// Per-frame collision and threat evaluator feeding the enemy movement block.
// Accumulates overlaps during a frame and reports them as one-cycle pulses
// in the cycle right after startOfFrame.
// Ports:
//   clk, resetN               clock, asynchronous active-low reset
//   startOfFrame              one-cycle frame boundary pulse
//   pause                     suppress pulses and discard the frame snapshot
//   pixelX/Y, topLeftX/Y      pixel position and enemy corner
//   enemyDrawingRequest       enemy pixel active (registered stage)
//   shotDrawingRequest[2:0]   shot pixels active (same stage)
//   boundaryDrawingRequest    side-wall pixel active (same stage)
//   shotCollision[2:0]        pulse: shots that hit the enemy last frame
//   changeDirection           pulse: enemy touched a wall last frame
//   dodgeBullet               pulse: a shot entered the dodge zone last frame
//   enemyDead                 level: enemy has been hit
//   hitCount[7:0]             saturating count of frames with a hit
module enemy_hit_detector
    import enemy_pkg::*;
#(
    parameter int OBJECT_WIDTH_X  = 30,
    parameter int OBJECT_HEIGHT_Y = 30,
    parameter int DODGE_MARGIN_X  = 16,
    parameter int DODGE_RANGE_Y   = 96
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   pause,
    input  logic [10:0]            pixelX,
    input  logic [10:0]            pixelY,
    input  logic [10:0]            topLeftX,
    input  logic [10:0]            topLeftY,
    input  logic                   enemyDrawingRequest,
    input  logic [NUM_SHOTS-1:0]   shotDrawingRequest,
    input  logic                   boundaryDrawingRequest,
    output logic [NUM_SHOTS-1:0]   shotCollision,
    output logic                   changeDirection,
    output logic                   dodgeBullet,
    output logic                   enemyDead,
    output logic [HIT_COUNT_W-1:0] hitCount
);

    logic                 zone_flag_d;
    logic [NUM_SHOTS-1:0] hit_now;
    logic [NUM_SHOTS-1:0] hit_acc_reg;
    logic [NUM_SHOTS-1:0] hit_acc_next;
    logic                 wall_now;
    logic                 wall_acc_reg;
    logic                 wall_acc_next;
    logic                 dodge_now;
    logic                 dodge_acc_reg;
    logic                 dodge_acc_next;
    logic                 report_en;
    enemy_life_t          life_reg;

    enemy_dodge_zone #(
        .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
        .OBJECT_HEIGHT_Y(OBJECT_HEIGHT_Y),
        .DODGE_MARGIN_X (DODGE_MARGIN_X),
        .DODGE_RANGE_Y  (DODGE_RANGE_Y)
    ) u_dodge_zone (
        .clk        (clk),
        .resetN     (resetN),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .topLeftX   (topLeftX),
        .topLeftY   (topLeftY),
        .zone_flag_d(zone_flag_d)
    );

    // On startOfFrame the old contents are dropped (they are being reported
    // this same cycle) and only the current request is kept, so a request
    // coinciding with the boundary belongs to the new frame.
    generate
        for (genvar gi = 0; gi < NUM_SHOTS; gi++) begin : g_hit
            assign hit_now[gi]      = enemyDrawingRequest & shotDrawingRequest[gi];
            assign hit_acc_next[gi] = hit_now[gi] | (hit_acc_reg[gi] & ~startOfFrame);
        end
    endgenerate

    assign wall_now       = enemyDrawingRequest & boundaryDrawingRequest;
    assign wall_acc_next  = wall_now | (wall_acc_reg & ~startOfFrame);
    assign dodge_now      = zone_flag_d & (|shotDrawingRequest);
    assign dodge_acc_next = dodge_now | (dodge_acc_reg & ~startOfFrame);

    // A paused boundary throws the finished frame away entirely.
    assign report_en = startOfFrame & ~pause;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_acc_reg   <= '0;
            wall_acc_reg  <= 1'b0;
            dodge_acc_reg <= 1'b0;
        end else begin
            hit_acc_reg   <= hit_acc_next;
            wall_acc_reg  <= wall_acc_next;
            dodge_acc_reg <= dodge_acc_next;
        end
    end

    // Life FSM and registered pulse outputs. Pulses default low every cycle,
    // so anything set on the boundary edge lasts exactly one cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            life_reg        <= ALIVE;
            shotCollision   <= '0;
            changeDirection <= 1'b0;
            dodgeBullet     <= 1'b0;
            enemyDead       <= 1'b0;
            hitCount        <= '0;
        end else begin
            shotCollision   <= '0;
            changeDirection <= 1'b0;
            dodgeBullet     <= 1'b0;

            // The counter tallies every reported hit frame, also after death,
            // so it keeps reflecting total hits taken.
            if (report_en && (|hit_acc_reg)) begin
                hitCount <= sat_inc8(hitCount);
            end

            case (life_reg)
                ALIVE: begin
                    if (report_en) begin
                        if (|hit_acc_reg) begin
                            // A hit wins the slot: wall and dodge are dropped.
                            shotCollision <= hit_acc_reg;
                            life_reg      <= HIT_REPORT;
                        end else begin
                            changeDirection <= wall_acc_reg;
                            dodgeBullet     <= dodge_acc_reg;
                        end
                    end
                end
                HIT_REPORT: begin
                    enemyDead <= 1'b1;
                    life_reg  <= DEAD;
                end
                default: begin
                    // DEAD: silent until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_hit_detector.sv
// Self-checking bench for enemy_hit_detector. A frame is a list of cycle
// records; the reference model summarises each frame as sets of events and
// predicts the pulses reported at the following frame boundary.
module tb_enemy_hit_detector;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        pause;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        enemyDrawingRequest;
    logic [2:0]  shotDrawingRequest;
    logic        boundaryDrawingRequest;
    logic [2:0]  shotCollision;
    logic        changeDirection;
    logic        dodgeBullet;
    logic        enemyDead;
    logic [7:0]  hitCount;

    always #5 clk = ~clk;

    enemy_hit_detector dut (
        .clk                   (clk),
        .resetN                (resetN),
        .startOfFrame          (startOfFrame),
        .pause                 (pause),
        .pixelX                (pixelX),
        .pixelY                (pixelY),
        .topLeftX              (topLeftX),
        .topLeftY              (topLeftY),
        .enemyDrawingRequest   (enemyDrawingRequest),
        .shotDrawingRequest    (shotDrawingRequest),
        .boundaryDrawingRequest(boundaryDrawingRequest),
        .shotCollision         (shotCollision),
        .changeDirection       (changeDirection),
        .dodgeBullet           (dodgeBullet),
        .enemyDead             (enemyDead),
        .hitCount              (hitCount)
    );

    typedef struct {
        int       x;
        int       y;
        bit       e;
        bit [2:0] s;
        bit       b;
    } rec_t;

    rec_t fq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int frame_no = 0;

    // Reference model state
    bit [2:0] p_hit;
    bit       p_wall;
    bit       p_dodge;
    bit       m_zone_prev;
    bit       m_killed;
    bit       m_dead_lvl;
    int       m_cnt;

    // Last observed report (pulse cycle after startOfFrame)
    logic [2:0] obs_sc;
    logic       obs_cd;
    logic       obs_db;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_zone(input int px, input int py, input int tlx, input int tly);
        int xl;
        xl = tlx - 16;
        if (xl < 0) xl = 0;
        return (px >= xl) && (px < tlx + 46) && (py >= tly + 30) && (py < tly + 126);
    endfunction

    function automatic rec_t mk(input int x, input int y, input bit e, input bit [2:0] s, input bit b);
        rec_t r;
        r.x = x; r.y = y; r.e = e; r.s = s; r.b = b;
        return r;
    endfunction

    // Pixel on one cycle, its drawing requests on the next (pipeline alignment).
    task automatic add_px(input int x, input int y, input bit e, input bit [2:0] s, input bit b);
        fq.push_back(mk(x, y, 1'b0, 3'b000, 1'b0));
        fq.push_back(mk(0, 0, e, s, b));
    endtask

    task automatic run_frame(input bit pz);
        bit [2:0] r_sc;
        bit       r_cd;
        bit       r_db;
        r_sc = 3'b000; r_cd = 1'b0; r_db = 1'b0;
        for (int k = 0; k < fq.size(); k++) begin
            pixelX                 = 11'(fq[k].x);
            pixelY                 = 11'(fq[k].y);
            enemyDrawingRequest    = fq[k].e;
            shotDrawingRequest     = fq[k].s;
            boundaryDrawingRequest = fq[k].b;
            startOfFrame           = (k == 0);
            pause                  = pz && (k < 2);
            if (k == 0) begin
                if (!pz) begin
                    if (p_hit != 0 && m_cnt < 255) m_cnt++;
                    if (!m_killed) begin
                        if (p_hit != 0) begin
                            r_sc     = p_hit;
                            m_killed = 1'b1;
                        end else begin
                            r_cd = p_wall;
                            r_db = p_dodge;
                        end
                    end
                end
                p_hit = 3'b000; p_wall = 1'b0; p_dodge = 1'b0;
            end
            if (fq[k].s != 0 && m_zone_prev) p_dodge = 1'b1;
            if (fq[k].e) begin
                p_hit = p_hit | fq[k].s;
                if (fq[k].b) p_wall = 1'b1;
            end
            m_zone_prev = in_zone(fq[k].x, fq[k].y, int'(topLeftX), int'(topLeftY));
            @(posedge clk);
            #1;
            if (k == 0) begin
                obs_sc = shotCollision;
                obs_cd = changeDirection;
                obs_db = dodgeBullet;
                check_val("pulse_sc", 32'(shotCollision), 32'(r_sc));
                check_val("pulse_cd", 32'(changeDirection), 32'(r_cd));
                check_val("pulse_db", 32'(dodgeBullet), 32'(r_db));
            end else begin
                check_val("idle_pulses", 32'({shotCollision, changeDirection, dodgeBullet}), 32'd0);
            end
            check_val("enemy_dead", 32'(enemyDead), 32'(m_dead_lvl));
            check_val("hit_count", 32'(hitCount), 32'(m_cnt));
            m_dead_lvl = m_killed;
        end
        startOfFrame = 1'b0;
        pause        = 1'b0;
        $display("frame %0d: tl=(%0d,%0d) recs=%0d pause=%0b -> sc=%b cd=%b db=%b dead=%b cnt=%0d",
                 frame_no, topLeftX, topLeftY, fq.size(), pz, obs_sc, obs_cd, obs_db, enemyDead, hitCount);
        frame_no++;
        fq.delete();
    endtask

    task automatic idle_frame(input bit pz);
        fq.push_back(mk(0, 0, 1'b0, 3'b000, 1'b0));
        fq.push_back(mk(0, 0, 1'b0, 3'b000, 1'b0));
        run_frame(pz);
    endtask

    task automatic do_reset();
        resetN                 = 1'b0;
        startOfFrame           = 1'b0;
        pause                  = 1'b0;
        enemyDrawingRequest    = 1'b0;
        shotDrawingRequest     = 3'b000;
        boundaryDrawingRequest = 1'b0;
        #1;
        check_val("rst_outputs", 32'({shotCollision, changeDirection, dodgeBullet, enemyDead}), 32'd0);
        check_val("rst_count", 32'(hitCount), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        resetN      = 1'b1;
        p_hit       = 3'b000;
        p_wall      = 1'b0;
        p_dodge     = 1'b0;
        m_zone_prev = 1'b0;
        m_killed    = 1'b0;
        m_dead_lvl  = 1'b0;
        m_cnt       = 0;
        $display("reset applied at t=%0t", $time);
    endtask

    task automatic set_tl(input int x, input int y);
        topLeftX = 11'(x);
        topLeftY = 11'(y);
    endtask

    initial begin
        pixelX = '0; pixelY = '0;
        set_tl(240, 200);
        do_reset();

        // Single hit by shot 1
        add_px(250, 210, 1'b1, 3'b010, 1'b0);
        run_frame(1'b0);
        idle_frame(1'b0);
        check_val("single_hit_sc", 32'(obs_sc), 32'd2);
        idle_frame(1'b0);
        check_val("single_hit_dead", 32'(enemyDead), 32'd1);
        check_val("single_hit_cnt", 32'(hitCount), 32'd1);

        // Wall touch, then a clean frame
        do_reset();
        set_tl(600, 200);
        add_px(610, 210, 1'b1, 3'b000, 1'b1);
        run_frame(1'b0);
        idle_frame(1'b0);
        check_val("wall_cd", 32'(obs_cd), 32'd1);
        check_val("wall_no_sc", 32'(obs_sc), 32'd0);
        idle_frame(1'b0);
        check_val("wall_once", 32'(obs_cd), 32'd0);

        // Dodge zone: inside, right of margin, below range
        do_reset();
        set_tl(240, 200);
        add_px(245, 260, 1'b0, 3'b001, 1'b0);
        run_frame(1'b0);
        idle_frame(1'b0);
        check_val("dodge_in", 32'(obs_db), 32'd1);
        add_px(300, 260, 1'b0, 3'b001, 1'b0);
        run_frame(1'b0);
        idle_frame(1'b0);
        check_val("dodge_right_out", 32'(obs_db), 32'd0);
        add_px(245, 326, 1'b0, 3'b001, 1'b0);
        run_frame(1'b0);
        idle_frame(1'b0);
        check_val("dodge_below_out", 32'(obs_db), 32'd0);

        // Left edge clamp
        set_tl(5, 200);
        add_px(0, 260, 1'b0, 3'b001, 1'b0);
        run_frame(1'b0);
        idle_frame(1'b0);
        check_val("left_edge_in", 32'(obs_db), 32'd1);
        add_px(2040, 260, 1'b0, 3'b001, 1'b0);
        run_frame(1'b0);
        idle_frame(1'b0);
        check_val("left_edge_nowrap", 32'(obs_db), 32'd0);

        // Hit + wall + dodge together: only the hit is reported
        do_reset();
        set_tl(240, 200);
        add_px(245, 260, 1'b0, 3'b001, 1'b0);
        add_px(250, 210, 1'b1, 3'b100, 1'b1);
        run_frame(1'b0);
        idle_frame(1'b0);
        check_val("combo_sc", 32'(obs_sc), 32'd4);
        check_val("combo_cd_db", 32'({obs_cd, obs_db}), 32'd0);

        // Hit on the startOfFrame cycle belongs to the new frame
        do_reset();
        fq.push_back(mk(250, 210, 1'b1, 3'b001, 1'b0));
        fq.push_back(mk(0, 0, 1'b0, 3'b000, 1'b0));
        run_frame(1'b0);
        check_val("sof_hit_not_early", 32'(obs_sc), 32'd0);
        idle_frame(1'b0);
        check_val("sof_hit_next", 32'(obs_sc), 32'd1);

        // Pause over the report discards the hit
        do_reset();
        add_px(250, 210, 1'b1, 3'b011, 1'b0);
        run_frame(1'b0);
        idle_frame(1'b1);
        check_val("pause_sc", 32'(obs_sc), 32'd0);
        idle_frame(1'b0);
        check_val("pause_lost", 32'(obs_sc), 32'd0);
        check_val("pause_alive", 32'(enemyDead), 32'd0);

        // Reset mid-frame after an overlap
        do_reset();
        add_px(250, 210, 1'b1, 3'b001, 1'b1);
        run_frame(1'b0);
        do_reset();
        idle_frame(1'b0);
        check_val("reset_midframe", 32'({obs_sc, obs_cd}), 32'd0);

        // Randomised frames
        for (int it = 0; it < 80; it++) begin
            int tlx;
            int tly;
            int n;
            if ($urandom_range(0, 4) == 0) do_reset();
            tlx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 19) : $urandom_range(20, 620);
            tly = $urandom_range(0, 400);
            set_tl(tlx, tly);
            n = $urandom_range(2, 12);
            for (int j = 0; j < n; j++) begin
                int x;
                x = ((tlx > 30) ? tlx - 30 : 0) + $urandom_range(0, 110);
                fq.push_back(mk(x, tly - 10 + $urandom_range(10, 150) - 10 + 10,
                                ($urandom_range(0, 3) == 0),
                                ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                                ($urandom_range(0, 5) == 0)));
            end
            run_frame($urandom_range(0, 5) == 0);
        end
        idle_frame(1'b0);

        // Hit counter saturation
        do_reset();
        set_tl(240, 200);
        for (int f = 0; f < 300; f++) begin
            add_px(250, 210, 1'b1, 3'b001, 1'b0);
            run_frame(1'b0);
        end
        idle_frame(1'b0);
        check_val("sat_count", 32'(hitCount), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
